// File: rtl/ocs_slot_scheduler_if.sv
// Scheduler-facing bundle: run/link status in, per-channel sync handshake out, OCS config out.
// The master modport is the scheduler side; the slave modport is the MAC/OCS environment side.
interface ocs_slot_scheduler_if #(
   parameter int P_CHANNEL_NUM = 8
);
   logic                     i_enable;
   logic [P_CHANNEL_NUM-1:0] i_link_up;
   logic [P_CHANNEL_NUM-1:0] o_sync_valid;
   logic [P_CHANNEL_NUM-1:0] i_sync_ready;
   logic [15:0]              o_slot_id;
   logic [7:0]               o_cfg_idx;
   logic                     o_ocs_switch;
   logic                     o_slot_active;
   logic [P_CHANNEL_NUM-1:0] o_sync_miss;
   logic                     o_link_err;
   logic [2:0]               o_state;

   modport master (
      input  i_enable, i_link_up, i_sync_ready,
      output o_sync_valid, o_slot_id, o_cfg_idx, o_ocs_switch,
             o_slot_active, o_sync_miss, o_link_err, o_state
   );

   modport slave (
      output i_enable, i_link_up, i_sync_ready,
      input  o_sync_valid, o_slot_id, o_cfg_idx, o_ocs_switch,
             o_slot_active, o_sync_miss, o_link_err, o_state
   );
endinterface

// File: rtl/ocs_slot_scheduler.sv
// OCS time-slot sequencer: link-stable wait, per-channel sync handshake, data slot, switch guard.
// All outputs registered (effects one cycle after the condition); sync valids hold until ready or timeout.
module ocs_slot_scheduler #(
   parameter int          P_CHANNEL_NUM   = 8,
   parameter logic [31:0] P_STABLE_CYCLES = 32'd1000,
   parameter logic [31:0] P_SLOT_CYCLES   = 32'd100000,
   parameter logic [31:0] P_SWITCH_CYCLES = 32'd2000,
   parameter logic [31:0] P_SYNC_TIMEOUT  = 32'd256
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   ocs_slot_scheduler_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_STABLE = 3'd1,
      ST_SYNC        = 3'd2,
      ST_SLOT        = 3'd3,
      ST_SWITCH      = 3'd4
   } state_t;

   localparam logic [31:0] STABLE_LAST = P_STABLE_CYCLES - 32'd1;
   localparam logic [31:0] SLOT_LAST   = P_SLOT_CYCLES - 32'd1;
   localparam logic [31:0] SWITCH_LAST = P_SWITCH_CYCLES - 32'd1;
   localparam logic [31:0] SYNC_LAST   = P_SYNC_TIMEOUT - 32'd1;
   localparam logic [7:0]  CFG_MAX     = 8'(P_CHANNEL_NUM - 1);

   state_t                   state_q, state_d;
   logic [31:0]              cnt_q, cnt_d;
   logic [P_CHANNEL_NUM-1:0] valid_q, valid_d;
   logic [P_CHANNEL_NUM-1:0] miss_q, miss_d;
   logic [15:0]              slot_id_q, slot_id_d;
   logic [7:0]               cfg_q, cfg_d;
   logic                     switch_q, switch_d;
   logic                     active_q, active_d;
   logic                     link_err_q, link_err_d;

   logic                     all_up;
   logic                     link_drop;
   logic [P_CHANNEL_NUM-1:0] pending;

   assign all_up    = &bus.i_link_up;
   assign link_drop = !all_up &&
                      (state_q == ST_SYNC || state_q == ST_SLOT || state_q == ST_SWITCH);
   // Bits still owed after this cycle's acceptances; same-cycle last accept beats timeout.
   assign pending   = valid_q & ~bus.i_sync_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 32'd1;
      valid_d    = valid_q;
      miss_d     = '0;
      slot_id_d  = slot_id_q;
      cfg_d      = cfg_q;
      switch_d   = 1'b0;
      active_d   = active_q;
      link_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d    = '0;
            valid_d  = '0;
            active_d = 1'b0;
            if (bus.i_enable) state_d = ST_WAIT_STABLE;
         end
         ST_WAIT_STABLE: begin
            if (!bus.i_enable) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (!all_up) begin
               cnt_d = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_SYNC;
               cnt_d   = '0;
               valid_d = '1;
            end
         end
         ST_SYNC: begin
            valid_d = pending;
            if (pending == '0) begin
               state_d  = ST_SLOT;
               cnt_d    = '0;
               active_d = 1'b1;
            end else if (cnt_q == SYNC_LAST) begin
               state_d  = ST_SLOT;
               cnt_d    = '0;
               active_d = 1'b1;
               miss_d   = pending;
               valid_d  = '0;
            end
         end
         ST_SLOT: begin
            if (cnt_q == SLOT_LAST) begin
               cnt_d    = '0;
               active_d = 1'b0;
               if (bus.i_enable) begin
                  state_d   = ST_SWITCH;
                  switch_d  = 1'b1;
                  slot_id_d = slot_id_q + 16'd1;
                  cfg_d     = (cfg_q >= CFG_MAX) ? 8'd1 : cfg_q + 8'd1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_SWITCH: begin
            if (cnt_q == SWITCH_LAST) begin
               state_d = ST_SYNC;
               cnt_d   = '0;
               valid_d = '1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // A dropped link overrides slot end, sync timeout and enable.
      if (link_drop) begin
         state_d    = ST_WAIT_STABLE;
         cnt_d      = '0;
         valid_d    = '0;
         miss_d     = '0;
         active_d   = 1'b0;
         switch_d   = 1'b0;
         cfg_d      = 8'd1;
         slot_id_d  = '0;
         link_err_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         valid_q    <= '0;
         miss_q     <= '0;
         slot_id_q  <= '0;
         cfg_q      <= 8'd1;
         switch_q   <= 1'b0;
         active_q   <= 1'b0;
         link_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         miss_q     <= miss_d;
         slot_id_q  <= slot_id_d;
         cfg_q      <= cfg_d;
         switch_q   <= switch_d;
         active_q   <= active_d;
         link_err_q <= link_err_d;
      end
   end

   assign bus.o_sync_valid  = valid_q;
   assign bus.o_sync_miss   = miss_q;
   assign bus.o_slot_id     = slot_id_q;
   assign bus.o_cfg_idx     = cfg_q;
   assign bus.o_ocs_switch  = switch_q;
   assign bus.o_slot_active = active_q;
   assign bus.o_link_err    = link_err_q;
   assign bus.o_state       = state_q;

endmodule
